// File: rtl/uart_pkg.sv
// Shared encodings and helpers for the UART transmit path.
// Baud and parity codes match the receiver so an identically configured pair interoperates.
package uart_pkg;

  typedef enum logic [1:0] {
    BAUD_2400  = 2'b00,
    BAUD_4800  = 2'b01,
    BAUD_9600  = 2'b10,
    BAUD_19200 = 2'b11
  } baud_rate_e;

  typedef enum logic [1:0] {
    PAR_NONE     = 2'b00,
    PAR_ODD      = 2'b01,
    PAR_EVEN     = 2'b10,
    PAR_NONE_ALT = 2'b11
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS  = 8;

  function automatic int baud_div(input int clk_freq, input logic [1:0] code);
    int rate;
    case (baud_rate_e'(code))
      BAUD_2400:  rate = 2400;
      BAUD_4800:  rate = 4800;
      BAUD_9600:  rate = 9600;
      default:    rate = 19200;
    endcase
    return clk_freq / rate;
  endfunction

  // No-parity codes drive the slot as a second stop-like 1.
  function automatic logic tx_parity(input logic [DATA_BITS-1:0] data, input logic [1:0] code);
    logic p;
    case (parity_e'(code))
      PAR_EVEN: p = ^data;
      PAR_ODD:  p = ~^data;
      default:  p = 1'b1;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/baud_gen_tx.sv
// Bit-period counter: counts 0..DIV-1 for the latched baud code and flags the wrap.
// Held at zero while clear is high so the first bit of a frame gets a full period.
module baud_gen_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic [1:0] baud,
  output logic       tick
);

  localparam int DIV_MAX = baud_div(CLK_FREQ, 2'b00);
  localparam int CNT_W   = (DIV_MAX > 2) ? $clog2(DIV_MAX) : 1;

  localparam logic [CNT_W-1:0] TOP_2400  = CNT_W'(baud_div(CLK_FREQ, 2'b00) - 1);
  localparam logic [CNT_W-1:0] TOP_4800  = CNT_W'(baud_div(CLK_FREQ, 2'b01) - 1);
  localparam logic [CNT_W-1:0] TOP_9600  = CNT_W'(baud_div(CLK_FREQ, 2'b10) - 1);
  localparam logic [CNT_W-1:0] TOP_19200 = CNT_W'(baud_div(CLK_FREQ, 2'b11) - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d, top;

  always_comb begin
    case (baud_rate_e'(baud))
      BAUD_2400: top = TOP_2400;
      BAUD_4800: top = TOP_4800;
      BAUD_9600: top = TOP_9600;
      default:   top = TOP_19200;
    endcase
  end

  assign tick = (cnt_q == top);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start, 8 data bits LSB first, parity slot, stop; 11*DIV cycles per frame.
// Outputs are registered from the next-state view so data_tx moves on the same edge as the FSM.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       send,
  input  logic [7:0] data_in,
  input  logic [1:0] parity_type,
  input  logic [1:0] baud_rate,
  output logic       data_tx,
  output logic       active_flag,
  output logic       done_flag
);

  tx_state_e      state_q, state_d;
  logic [7:0]     shift_q, shift_d;
  logic [2:0]     idx_q, idx_d;
  logic           par_q, par_d;
  logic [1:0]     baud_q, baud_d;
  logic           tx_q, tx_d;
  logic           active_q, active_d;
  logic           done_q, done_d;
  logic           tick;

  // Counter idles cleared, which also covers the clear-on-accept.
  baud_gen_tx #(.CLK_FREQ(CLK_FREQ)) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state_q == ST_IDLE),
    .baud  (baud_q),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      par_q    <= 1'b0;
      baud_q   <= '0;
      tx_q     <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      par_q    <= par_d;
      baud_q   <= baud_d;
      tx_q     <= tx_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    par_d   = par_q;
    baud_d  = baud_q;
    case (state_q)
      ST_IDLE: if (send) begin
        state_d = ST_START;
        shift_d = data_in;
        baud_d  = baud_rate;
        par_d   = tx_parity(data_in, parity_type);
        idx_d   = '0;
      end
      ST_START: if (tick) state_d = ST_DATA;
      ST_DATA: if (tick) begin
        if (idx_q == 3'(DATA_BITS - 1)) begin
          state_d = ST_PARITY;
        end else begin
          idx_d   = idx_q + 3'd1;
          shift_d = {1'b0, shift_q[7:1]};
        end
      end
      ST_PARITY: if (tick) state_d = ST_STOP;
      ST_STOP:   if (tick) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_d     = 1'b1;
    active_d = (state_d != ST_IDLE);
    done_d   = (state_q == ST_STOP) && tick;
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  assign data_tx     = tx_q;
  assign active_flag = active_q;
  assign done_flag   = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame at CLK_FREQ = 192000 (DIV = 80/40/20/10).
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       send = 1'b0;
  logic [7:0] data_in = '0;
  logic [1:0] parity_type = '0;
  logic [1:0] baud_rate = '0;
  logic       data_tx, active_flag, done_flag;

  int checks = 0;
  int failures = 0;

  uart_tx_frame #(.CLK_FREQ(192000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .send        (send),
    .data_in     (data_in),
    .parity_type (parity_type),
    .baud_rate   (baud_rate),
    .data_tx     (data_tx),
    .active_flag (active_flag),
    .done_flag   (done_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Observes one frame; called at a sample point with send already raised.
  // bits[i] is frame slot i sampled mid-bit; window runs two cycles past the frame.
  task automatic capture(input int div, input bit hold, input int poke,
                         output logic [10:0] bits, output int act_cnt, output int done_cnt,
                         output int done_at, output int low_cnt, output int hi_run,
                         output logic tx_first, output logic tx_after, output logic act_after);
    bits = '0; act_cnt = 0; done_cnt = 0; done_at = -1; low_cnt = 0; hi_run = 0;
    tx_first = 1'bx; tx_after = 1'bx; act_after = 1'bx;
    step();
    if (!hold) send = 1'b0;
    for (int c = 0; c <= 11*div + 1; c++) begin
      if (c == poke) begin
        send = 1'b1; data_in = 8'h81; baud_rate = 2'b00; parity_type = 2'b01;
      end else if (c == poke + 1 && !hold) begin
        send = 1'b0;
      end
      if (c == 0) tx_first = data_tx;
      if (c < 11*div && (c % div) == div/2) bits[c/div] = data_tx;
      if (c <= 11*div) begin
        if (active_flag) act_cnt++;
        if (!data_tx && c < 11*div) low_cnt++;
        hi_run = data_tx ? hi_run + 1 : 0;
      end
      if (done_flag) begin done_cnt++; done_at = c; end
      if (c == 11*div + 1) begin tx_after = data_tx; act_after = active_flag; end
      step();
    end
  endtask

  task automatic test_reset();
    int bad = 0;
    repeat (3) step();
    checks++;
    if (data_tx !== 1'b1 || active_flag !== 1'b0 || done_flag !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: tx=%b act=%b done=%b expected 1 0 0", data_tx, active_flag, done_flag);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if (data_tx !== 1'b1 || active_flag !== 1'b0 || done_flag !== 1'b0) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL idle_quiet: %0d bad idle cycles, expected 0", bad);
    end
  endtask

  task automatic test_even_parity();
    logic [10:0] bits; int act, dn, dat, low, hr; logic t0, ta, aa;
    data_in = 8'hA5; parity_type = 2'b10; baud_rate = 2'b11; send = 1'b1;
    capture(10, 1'b0, -1, bits, act, dn, dat, low, hr, t0, ta, aa);
    // line 0,1,0,1,0,0,1,0,1,0,1 in slot order
    checks++; if (bits !== 11'h54A) begin failures++; $display("FAIL even_bits: got %h expected 54a", bits); end
    checks++; if (t0 !== 1'b0) begin failures++; $display("FAIL even_start_latency: tx=%b expected 0", t0); end
    checks++; if (act != 110) begin failures++; $display("FAIL even_active_len: %0d expected 110", act); end
    checks++; if (dn != 1 || dat != 110) begin
      failures++; $display("FAIL even_done: count=%0d at=%0d expected 1 at 110", dn, dat);
    end
  endtask

  task automatic test_odd_slow();
    logic [10:0] bits; int act, dn, dat, low, hr; logic t0, ta, aa;
    data_in = 8'h00; parity_type = 2'b01; baud_rate = 2'b00; send = 1'b1;
    capture(80, 1'b0, -1, bits, act, dn, dat, low, hr, t0, ta, aa);
    checks++; if (bits !== 11'h600) begin failures++; $display("FAIL odd_bits: got %h expected 600", bits); end
    checks++; if (act != 880) begin failures++; $display("FAIL odd_active_len: %0d expected 880", act); end
    checks++; if (low != 720) begin failures++; $display("FAIL odd_low_cycles: %0d expected 720", low); end
    checks++; if (dn != 1 || dat != 880) begin
      failures++; $display("FAIL odd_done: count=%0d at=%0d expected 1 at 880", dn, dat);
    end
  endtask

  task automatic test_no_parity();
    logic [10:0] bits; int act, dn, dat, low, hr; logic t0, ta, aa;
    data_in = 8'hFF; parity_type = 2'b11; baud_rate = 2'b10; send = 1'b1;
    capture(20, 1'b0, -1, bits, act, dn, dat, low, hr, t0, ta, aa);
    checks++; if (bits !== 11'h7FE) begin failures++; $display("FAIL nopar_bits: got %h expected 7fe", bits); end
    checks++; if (low != 20) begin failures++; $display("FAIL nopar_low_cycles: %0d expected 20", low); end
    checks++; if (act != 220) begin failures++; $display("FAIL nopar_active_len: %0d expected 220", act); end
  endtask

  task automatic test_busy_latch();
    logic [10:0] bits; int act, dn, dat, low, hr; logic t0, ta, aa;
    data_in = 8'h3C; parity_type = 2'b10; baud_rate = 2'b11; send = 1'b1;
    capture(10, 1'b0, 33, bits, act, dn, dat, low, hr, t0, ta, aa);
    checks++; if (bits !== 11'h478) begin failures++; $display("FAIL busy_bits: got %h expected 478", bits); end
    checks++; if (act != 110) begin failures++; $display("FAIL busy_active_len: %0d expected 110", act); end
    checks++; if (dn != 1) begin failures++; $display("FAIL busy_done_count: %0d expected 1", dn); end
    checks++; if (ta !== 1'b1 || aa !== 1'b0) begin
      failures++; $display("FAIL busy_no_queue: tx=%b act=%b after frame, expected 1 0", ta, aa);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] bits; int act, dn, dat, low, hr; logic t0, ta, aa;
    int second_done = -1;
    data_in = 8'h3C; parity_type = 2'b10; baud_rate = 2'b11; send = 1'b1;
    capture(10, 1'b1, -1, bits, act, dn, dat, low, hr, t0, ta, aa);
    checks++; if (bits !== 11'h478) begin failures++; $display("FAIL b2b_first_bits: got %h expected 478", bits); end
    // Stop bit (10 cycles) plus the done/IDLE cycle in which the next send is taken.
    checks++; if (hr != 11) begin failures++; $display("FAIL b2b_gap: high run %0d expected 11", hr); end
    checks++; if (ta !== 1'b0 || aa !== 1'b1) begin
      failures++; $display("FAIL b2b_restart: tx=%b act=%b expected 0 1", ta, aa);
    end
    send = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      if (done_flag && second_done < 0) second_done = n;
      step();
    end
    checks++; if (second_done != 110) begin
      failures++; $display("FAIL b2b_second_done: at %0d expected 110", second_done);
    end
  endtask

  task automatic test_mid_reset();
    logic [10:0] bits; int act, dn, dat, low, hr; logic t0, ta, aa;
    int done_seen = 0;
    data_in = 8'hA5; parity_type = 2'b10; baud_rate = 2'b11; send = 1'b1;
    step();
    send = 1'b0;
    repeat (45) step();
    // Cycle 45 sits in data bit 3 of 0xA5, which is 0.
    checks++; if (data_tx !== 1'b0 || active_flag !== 1'b1) begin
      failures++; $display("FAIL midrst_pre: tx=%b act=%b expected 0 1", data_tx, active_flag);
    end
    rst_n = 1'b0;
    #1;
    checks++; if (data_tx !== 1'b1 || active_flag !== 1'b0) begin
      failures++; $display("FAIL midrst_async: tx=%b act=%b expected 1 0", data_tx, active_flag);
    end
    for (int i = 0; i < 5; i++) begin step(); if (done_flag) done_seen++; end
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin step(); if (done_flag || active_flag) done_seen++; end
    checks++; if (done_seen != 0) begin failures++; $display("FAIL midrst_no_done: %0d cycles with done/active, expected 0", done_seen); end
    data_in = 8'h3C; parity_type = 2'b01; baud_rate = 2'b10; send = 1'b1;
    capture(20, 1'b0, -1, bits, act, dn, dat, low, hr, t0, ta, aa);
    checks++; if (bits !== 11'h678) begin failures++; $display("FAIL midrst_new_bits: got %h expected 678", bits); end
    checks++; if (act != 220 || dn != 1 || dat != 220) begin
      failures++; $display("FAIL midrst_new_frame: act=%0d done=%0d at=%0d expected 220 1 220", act, dn, dat);
    end
  endtask

  initial begin
    test_reset();
    test_even_parity();
    test_odd_slow();
    test_no_parity();
    test_busy_latch();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
